sram_bist_march_ctrl: RTL and testbench

March C- built-in self-test controller for the single-port 2048x64 SRAM macro with a BIST port.
- Drives the macro's BIST port (`A_BIST_EN`/`MEN`/`WEN`/`REN`/`ADDR`/`DIN`/`BM`) on the BIST clock.
- Compares `A_DOUT` against expected data and reports pass/fail with first-failure diagnostics.
- Sits between the test-access/JTAG register block (start, status) and the macro. The macro consumes the generated operations; this block consumes the macro's read data.

---
 rtl/sram_bist_march_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_sram_bist_march_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_march_ctrl.sv
// sram_bist_march_ctrl
//   March C- BIST controller for a single-port SRAM macro with a BIST port.
//   Generates the six-element march sequence on the macro's BIST port and
//   compares the read data returned one cycle later. It reports pass/fail,
//   the count of mismatching reads, and the address and element of the
//   first mismatch.
//
//   Compile-time option: BIST_CHECKERBOARD_EN
//     defined     : background B = ...0101 (0x5555...), ~B = 0xAAAA...
//                   (DATA_WIDTH is assumed to be even)
//     not defined : background B = all zeros, ~B = all ones
//
// Ports
//   A_BIST_CLK   in   BIST clock (shared with the macro)
//   A_BIST_RST   in   asynchronous active-high reset
//   start        in   level; launches a run from IDLE or DONE
//   A_DOUT       in   macro read data (valid one cycle after a read op)
//   A_BIST_EN    out  selects the macro BIST port; high only while busy
//   A_BIST_MEN   out  memory enable for the current op
//   A_BIST_WEN   out  write strobe
//   A_BIST_REN   out  read strobe
//   A_BIST_ADDR  out  op address
//   A_BIST_DIN   out  write data (held across read ops)
//   A_BIST_BM    out  bit mask: all ones on writes, zero otherwise
//   busy         out  run in progress
//   done         out  run finished; held until next start or reset
//   pass         out  valid with done; 1 = no mismatch
//   fail_addr    out  address of the first mismatching read
//   fail_elem    out  march element (0..5) of the first mismatch
//   fail_cnt     out  mismatching read count, saturating at 0xFFFF
module sram_bist_march_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  A_BIST_CLK,
    input  logic                  A_BIST_RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A_DOUT,
    output logic                  A_BIST_EN,
    output logic                  A_BIST_MEN,
    output logic                  A_BIST_WEN,
    output logic                  A_BIST_REN,
    output logic [ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [DATA_WIDTH-1:0] A_BIST_BM,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [15:0]           fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

`ifdef BIST_CHECKERBOARD_EN
    localparam logic [DATA_WIDTH-1:0] BG = {(DATA_WIDTH/2){2'b01}};
`else
    localparam logic [DATA_WIDTH-1:0] BG = '0;
`endif
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [15:0]           CNT_MAX  = '1;

    state_t                  state_q;
    logic [2:0]              elem_q;
    logic                    phase_q;   // 0: read slot, 1: write slot (E1..E4)
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    en_q, men_q, wen_q, ren_q;
    logic [DATA_WIDTH-1:0]   din_q, bm_q;
    logic                    busy_q, done_q, pass_q;
    logic [ADDR_WIDTH-1:0]   fail_addr_q;
    logic [2:0]              fail_elem_q;
    logic [15:0]             fail_cnt_q;

    // Compare pipeline: describes the read op issued in the previous cycle,
    // whose data is on A_DOUT during the current cycle.
    logic                    cmp_vld_q;
    logic [DATA_WIDTH-1:0]   cmp_exp_q;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q;
    logic [2:0]              cmp_elem_q;

    // Next-op sequencing
    logic                    rw_elem_d, desc_d, last_op_d;
    logic [2:0]              nxt_elem_d;
    logic                    nxt_phase_d;
    logic [ADDR_WIDTH-1:0]   nxt_addr_d;
    logic                    nxt_wr_d, nxt_inv_d;
    logic [DATA_WIDTH-1:0]   nxt_word_d, cur_exp_d;
    logic                    mismatch_d;

    always_comb begin
        rw_elem_d   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        desc_d      = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_op_d   = (elem_q == 3'd5) && (addr_q == ADDR_MAX);
        nxt_elem_d  = elem_q;
        nxt_addr_d  = addr_q;
        nxt_phase_d = 1'b0;

        if (rw_elem_d && !phase_q) begin
            nxt_phase_d = 1'b1;
        end else if (desc_d) begin
            if (addr_q == '0) begin
                nxt_elem_d = elem_q + 3'd1;
                // E3 -> E4 restarts at the top; E4 -> E5 ascends from zero
                nxt_addr_d = (nxt_elem_d == 3'd4) ? ADDR_MAX : '0;
            end else begin
                nxt_addr_d = addr_q - 1'b1;
            end
        end else begin
            if (addr_q == ADDR_MAX) begin
                nxt_elem_d = elem_q + 3'd1;
                nxt_addr_d = (nxt_elem_d == 3'd3) ? ADDR_MAX : '0;
            end else begin
                nxt_addr_d = addr_q + 1'b1;
            end
        end

        nxt_wr_d   = (nxt_elem_d == 3'd0) ||
                     ((nxt_elem_d >= 3'd1) && (nxt_elem_d <= 3'd4) && nxt_phase_d);
        // Writes of ~B happen in E1/E3; reads of ~B happen in E2/E4
        nxt_inv_d  = nxt_wr_d ? ((nxt_elem_d == 3'd1) || (nxt_elem_d == 3'd3))
                              : ((nxt_elem_d == 3'd2) || (nxt_elem_d == 3'd4));
        nxt_word_d = nxt_inv_d ? ~BG : BG;

        cur_exp_d  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BG : BG;
        mismatch_d = cmp_vld_q && (A_DOUT != cmp_exp_q);
    end

    always_ff @(posedge A_BIST_CLK or posedge A_BIST_RST) begin
        if (A_BIST_RST) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            din_q       <= '0;
            bm_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_cnt_q  <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
        end else begin
            cmp_vld_q  <= (state_q == ST_RUN) && ren_q;
            cmp_exp_q  <= cur_exp_d;
            cmp_addr_q <= addr_q;
            cmp_elem_q <= elem_q;

            if (mismatch_d) begin
                pass_q <= 1'b0;
                if (fail_cnt_q != CNT_MAX) begin
                    fail_cnt_q <= fail_cnt_q + 16'd1;
                end
                if (fail_cnt_q == '0) begin
                    fail_addr_q <= cmp_addr_q;
                    fail_elem_q <= cmp_elem_q;
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b1;
                        fail_addr_q <= '0;
                        fail_elem_q <= '0;
                        fail_cnt_q  <= '0;
                        elem_q      <= '0;
                        phase_q     <= 1'b0;
                        addr_q      <= '0;
                        en_q        <= 1'b1;
                        men_q       <= 1'b1;
                        wen_q       <= 1'b1;
                        ren_q       <= 1'b0;
                        bm_q        <= '1;
                        din_q       <= BG;
                    end
                end
                ST_RUN: begin
                    if (last_op_d) begin
                        state_q <= ST_DRAIN;
                        men_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        ren_q   <= 1'b0;
                        bm_q    <= '0;
                    end else begin
                        elem_q  <= nxt_elem_d;
                        phase_q <= nxt_phase_d;
                        addr_q  <= nxt_addr_d;
                        wen_q   <= nxt_wr_d;
                        ren_q   <= !nxt_wr_d;
                        bm_q    <= nxt_wr_d ? '1 : '0;
                        if (nxt_wr_d) begin
                            din_q <= nxt_word_d;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    en_q    <= 1'b0;
                    addr_q  <= '0;
                    din_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign A_BIST_EN   = en_q;
    assign A_BIST_MEN  = men_q;
    assign A_BIST_WEN  = wen_q;
    assign A_BIST_REN  = ren_q;
    assign A_BIST_ADDR = addr_q;
    assign A_BIST_DIN  = din_q;
    assign A_BIST_BM   = bm_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_addr   = fail_addr_q;
    assign fail_elem   = fail_elem_q;
    assign fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_sram_bist_march_ctrl.sv
// Testbench for sram_bist_march_ctrl with a 16x64 behavioural macro model.
// Run results are scoreboarded: stimulus pushes the expected outcome, a
// monitor pops and compares it when done rises. The monitor also records
// the per-cycle op stream of each run for the stimulus to inspect.
module tb_sram_bist_march_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 4;

`ifdef BIST_CHECKERBOARD_EN
    localparam logic [DW-1:0] B = 64'h5555555555555555;
`else
    localparam logic [DW-1:0] B = 64'h0000000000000000;
`endif
    localparam logic [DW-1:0] NB = ~B;

    logic          clk, rst, start;
    logic [DW-1:0] dout;
    logic          en, men, wen, ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, bm;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [15:0]   fail_cnt;

    sram_bist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .A_BIST_CLK (clk),
        .A_BIST_RST (rst),
        .start      (start),
        .A_DOUT     (dout),
        .A_BIST_EN  (en),
        .A_BIST_MEN (men),
        .A_BIST_WEN (wen),
        .A_BIST_REN (ren),
        .A_BIST_ADDR(addr),
        .A_BIST_DIN (din),
        .A_BIST_BM  (bm),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_cnt   (fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Macro model: one-cycle read latency, optional stuck-at-1 on bit 3 of word 5
    logic [DW-1:0] mem [16];
    logic          fault_en;
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        dout = '0;
    end
    always @(posedge clk) begin
        if (en && men) begin
            if (wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
            if (ren) dout <= mem[addr] | ((fault_en && addr == 4'd5) ? 64'h8 : 64'h0);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        pass;
        logic [3:0]  faddr;
        logic [2:0]  felem;
        logic [15:0] fcnt;
        int          cycles;
    } exp_t;
    exp_t exp_q[$];

    // Per-run op trace, indexed by busy cycle
    logic [3:0]    tr_addr [256];
    logic [3:0]    tr_ctl  [256];   // {en, men, wen, ren}
    logic [DW-1:0] tr_din  [256];
    logic [DW-1:0] tr_bm   [256];

    int   bcnt = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bcnt      = 0;
            done_prev = 1'b0;
        end else begin
            if (busy && done) begin
                n_checks++;
                $display("FAIL busy_done_overlap: actual busy=1 done=1 required not both");
            end
            if (busy) begin
                if (bcnt < 256) begin
                    tr_addr[bcnt] = addr;
                    tr_ctl[bcnt]  = {en, men, wen, ren};
                    tr_din[bcnt]  = din;
                    tr_bm[bcnt]   = bm;
                end
                bcnt++;
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: actual done=1 required no run pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("busy_cycles", 64'(bcnt), 64'(e.cycles));
                    check("pass", {63'd0, pass}, {63'd0, e.pass});
                    check("fail_cnt", {48'd0, fail_cnt}, {48'd0, e.fcnt});
                    check("fail_addr", {60'd0, fail_addr}, {60'd0, e.faddr});
                    check("fail_elem", {61'd0, fail_elem}, {61'd0, e.felem});
                end
                bcnt = 0;
            end
            done_prev = done;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: actual done=0 after %0d cycles required done=1", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        fault_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_status", {60'd0, busy, done, pass, en}, 64'd0);
        check("rst_ctl", {61'd0, men, wen, ren}, 64'd0);
        check("rst_fail_cnt", {48'd0, fail_cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fault-free run
        exp_q.push_back('{pass: 1'b1, faddr: 4'd0, felem: 3'd0, fcnt: 16'd0, cycles: 161});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("run1");
        check("first_op_ctl", {60'd0, tr_ctl[0]}, {60'd0, 4'b1110});
        check("first_op_addr", {60'd0, tr_addr[0]}, 64'd0);
        check("first_op_din", tr_din[0], B);
        check("first_op_bm", tr_bm[0], '1);
        check("e1_read_bm", tr_bm[16], 64'd0);
        check("e1_write_din", tr_din[17], NB);
        for (int k = 0; k < 32; k++) begin
            logic [3:0] ea;
            ea = 4'(15 - k / 2);
            check("e3_op", {58'd0, tr_addr[80 + k], tr_ctl[80 + k][1:0]},
                  {58'd0, ea, (k % 2 == 1) ? 2'b10 : 2'b01});
        end
        check("drain_ctl", {60'd0, tr_ctl[160]}, {60'd0, 4'b1000});
        @(negedge clk);
        check("done_held", {62'd0, busy, done}, 64'd1);

        // Reset in the middle of a run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", {59'd0, en, men, busy, done, pass}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back('{pass: 1'b1, faddr: 4'd0, felem: 3'd0, fcnt: 16'd0, cycles: 161});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("run_after_rst");

        // Stuck-at fault with start held high across two runs
        fault_en = 1'b1;
        exp_q.push_back('{pass: 1'b0, faddr: 4'd5, felem: 3'd1, fcnt: 16'd3, cycles: 161});
        exp_q.push_back('{pass: 1'b0, faddr: 4'd5, felem: 3'd1, fcnt: 16'd3, cycles: 161});
        start = 1'b1;
        @(negedge clk);
        wait_done("fault_run1");
        @(negedge clk);
        check("restart_status", {61'd0, busy, done, pass}, {61'd0, 3'b101});
        check("restart_cleared", {41'd0, fail_cnt, fail_addr, fail_elem}, 64'd0);
        start = 1'b0;
        wait_done("fault_run2");
        repeat (3) @(negedge clk);
        check("no_restart", {61'd0, busy, done, pass}, {61'd0, 3'b010});

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
